// File: rtl/alu_mon_pkg.sv
// Shared definitions for the ALU result monitor: aluctrl codes, FSM states
// and the helper that tells which codes are actually compared.
package alu_mon_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mon_state_t;

  // Codes 011/100/101 have no golden model and are counted as skipped.
  function automatic logic is_checked_code(input logic [2:0] ctrl);
    return (ctrl == ALU_AND) || (ctrl == ALU_OR) || (ctrl == ALU_ADD) ||
           (ctrl == ALU_SUB) || (ctrl == ALU_SLT);
  endfunction

endpackage

// File: rtl/alu_golden.sv
// Combinational reference ALU: the result the DUT ALU is expected to produce
// for a given operand pair and control code.
module alu_golden
  import alu_mon_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  aluctrl,
  output logic [31:0] result,
  output logic        zero,
  output logic        valid_code
);

  always_comb begin
    result = '0;
    case (aluctrl)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {31'b0, ($signed(a) < $signed(b))};
      default: result = '0;
    endcase
  end

  assign zero       = (result == '0);
  assign valid_code = is_checked_code(aluctrl);

endmodule

// File: rtl/alu_result_monitor.sv
// Checks a stream of ALU transactions against alu_golden and keeps saturating
// pass/fail/skip counts; first-fail capture exists only with ALU_MON_FAILCAP_EN.
module alu_result_monitor
  import alu_mon_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] n_ops,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      a,
  input  logic [31:0]      b,
  input  logic [2:0]       aluctrl,
  input  logic [31:0]      res,
  input  logic             zero,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] skip_cnt,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [2:0]       first_fail_ctrl,
  output logic [31:0]      first_fail_res
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  mon_state_t       state, state_next;
  logic [CNT_W-1:0] n_ops_q;
  logic [CNT_W-1:0] op_idx;
  logic [31:0]      gold_result;
  logic             gold_zero;
  logic             gold_valid;
  logic             accept;
  logic             last_op;
  logic             start_take;
  logic             match;

  alu_golden u_golden (
    .a          (a),
    .b          (b),
    .aluctrl    (aluctrl),
    .result     (gold_result),
    .zero       (gold_zero),
    .valid_code (gold_valid)
  );

  assign accept     = in_valid && in_ready;
  assign last_op    = (op_idx == (n_ops_q - ONE));
  assign start_take = start && (state != RUN);
  assign match      = (res == gold_result) && (zero == gold_zero);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start) state_next = (n_ops == '0) ? DONE : RUN;
      RUN:        if (accept && last_op) state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == RUN);
    busy     = (state == RUN);
    done     = (state == DONE);
  end

  // Counters update on the acceptance edge, so they land together with done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_ops_q  <= '0;
      op_idx   <= '0;
      pass_cnt <= '0;
      fail_cnt <= '0;
      skip_cnt <= '0;
    end else if (start_take) begin
      n_ops_q  <= n_ops;
      op_idx   <= '0;
      pass_cnt <= '0;
      fail_cnt <= '0;
      skip_cnt <= '0;
    end else if (accept) begin
      op_idx <= op_idx + ONE;
      if (!gold_valid) begin
        if (skip_cnt != '1) skip_cnt <= skip_cnt + ONE;
      end else if (match) begin
        if (pass_cnt != '1) pass_cnt <= pass_cnt + ONE;
      end else begin
        if (fail_cnt != '1) fail_cnt <= fail_cnt + ONE;
      end
    end
  end

`ifdef ALU_MON_FAILCAP_EN
  logic fail_seen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_seen       <= 1'b0;
      first_fail_idx  <= '0;
      first_fail_ctrl <= '0;
      first_fail_res  <= '0;
    end else if (start_take) begin
      fail_seen       <= 1'b0;
      first_fail_idx  <= '0;
      first_fail_ctrl <= '0;
      first_fail_res  <= '0;
    end else if (accept && gold_valid && !match && !fail_seen) begin
      fail_seen       <= 1'b1;
      first_fail_idx  <= op_idx;
      first_fail_ctrl <= aluctrl;
      first_fail_res  <= res;
    end
  end
`else
  assign first_fail_idx  = '0;
  assign first_fail_ctrl = '0;
  assign first_fail_res  = '0;
`endif

endmodule

// File: tb/tb_alu_result_monitor.sv
// Table-driven bench for alu_result_monitor; first-fail expectations follow
// ALU_MON_FAILCAP_EN (zero when the capture feature is not built).
module tb_alu_result_monitor;

  localparam int CNT_W = 16;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  ctrl;
    logic [31:0] res;
    logic        zero;
  } txn_t;

  typedef struct {
    int          first;
    int          n;
    logic [31:0] exp_pass;
    logic [31:0] exp_fail;
    logic [31:0] exp_skip;
    logic [31:0] exp_ff_idx;
    logic [31:0] exp_ff_ctrl;
    logic [31:0] exp_ff_res;
  } run_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] n_ops;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      a;
  logic [31:0]      b;
  logic [2:0]       aluctrl;
  logic [31:0]      res;
  logic             zero;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic [CNT_W-1:0] skip_cnt;
  logic [CNT_W-1:0] first_fail_idx;
  logic [2:0]       first_fail_ctrl;
  logic [31:0]      first_fail_res;

  int   checks = 0;
  int   passes = 0;
  txn_t txns[16];
  run_t runs[5];

  always #5 clk = ~clk;

  alu_result_monitor #(.CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .n_ops           (n_ops),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .a               (a),
    .b               (b),
    .aluctrl         (aluctrl),
    .res             (res),
    .zero            (zero),
    .busy            (busy),
    .done            (done),
    .pass_cnt        (pass_cnt),
    .fail_cnt        (fail_cnt),
    .skip_cnt        (skip_cnt),
    .first_fail_idx  (first_fail_idx),
    .first_fail_ctrl (first_fail_ctrl),
    .first_fail_res  (first_fail_res)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else
      passes++;
  endtask

  task automatic checkFirstFail(input string tag, input logic [31:0] idx,
                                input logic [31:0] ctrl, input logic [31:0] fres);
`ifdef ALU_MON_FAILCAP_EN
    checkOutput({tag, " first_fail_idx"},  32'(first_fail_idx),  idx);
    checkOutput({tag, " first_fail_ctrl"}, 32'(first_fail_ctrl), ctrl);
    checkOutput({tag, " first_fail_res"},  first_fail_res,       fres);
`else
    checkOutput({tag, " first_fail_idx"},  32'(first_fail_idx),  32'(idx & 32'h0));
    checkOutput({tag, " first_fail_ctrl"}, 32'(first_fail_ctrl), 32'(ctrl & 32'h0));
    checkOutput({tag, " first_fail_res"},  first_fail_res,       32'(fres & 32'h0));
`endif
  endtask

  task automatic driveTxn(input int idx);
    a        = txns[idx].a;
    b        = txns[idx].b;
    aluctrl  = txns[idx].ctrl;
    res      = txns[idx].res;
    zero     = txns[idx].zero;
    in_valid = 1'b1;
  endtask

  task automatic pulseStart(input int n);
    @(negedge clk);
    start = 1'b1;
    n_ops = CNT_W'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  // One table run: start, feed n transactions (bubble before the second), check results.
  task automatic applyStimulus(input int r);
    string tag;
    tag = $sformatf("run%0d", r);
    pulseStart(runs[r].n);
    for (int k = 0; k < runs[r].n; k++) begin
      if (k == 1) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      driveTxn(runs[r].first + k);
      checkOutput($sformatf("%s in_ready[%0d]", tag, k), 32'(in_ready), 32'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    checkOutput({tag, " done"},     32'(done),     32'd1);
    checkOutput({tag, " busy"},     32'(busy),     32'd0);
    checkOutput({tag, " pass_cnt"}, 32'(pass_cnt), runs[r].exp_pass);
    checkOutput({tag, " fail_cnt"}, 32'(fail_cnt), runs[r].exp_fail);
    checkOutput({tag, " skip_cnt"}, 32'(skip_cnt), runs[r].exp_skip);
    checkFirstFail(tag, runs[r].exp_ff_idx, runs[r].exp_ff_ctrl, runs[r].exp_ff_res);
  endtask

  initial begin
    // a=0x45 b=0x85, all five checked codes with correct results
    txns[0]  = '{32'h45, 32'h85, 3'b010, 32'h0000_00CA, 1'b0};
    txns[1]  = '{32'h45, 32'h85, 3'b110, 32'hFFFF_FFC0, 1'b0};
    txns[2]  = '{32'h45, 32'h85, 3'b000, 32'h0000_0005, 1'b0};
    txns[3]  = '{32'h45, 32'h85, 3'b001, 32'h0000_00C5, 1'b0};
    txns[4]  = '{32'h45, 32'h85, 3'b111, 32'h0000_0001, 1'b0};
    // second transaction is a sub reporting the add result
    txns[5]  = '{32'h45, 32'h85, 3'b010, 32'h0000_00CA, 1'b0};
    txns[6]  = '{32'h45, 32'h85, 3'b110, 32'h0000_00CA, 1'b0};
    txns[7]  = '{32'h45, 32'h85, 3'b000, 32'h0000_0005, 1'b0};
    // right result, wrong zero flag; then an unchecked code
    txns[8]  = '{32'h7, 32'h7, 3'b110, 32'h0, 1'b0};
    txns[9]  = '{32'h7, 32'h7, 3'b011, 32'h1234, 1'b0};
    // signed slt and add wraparound, then an unsigned-style slt answer
    txns[10] = '{32'h8000_0000, 32'h1, 3'b111, 32'h1, 1'b0};
    txns[11] = '{32'hFFFF_FFFF, 32'h1, 3'b010, 32'h0, 1'b1};
    txns[12] = '{32'h8000_0000, 32'h1, 3'b111, 32'h0, 1'b1};
    // two skipped codes and an or with a bogus zero flag
    txns[13] = '{32'h1, 32'h2, 3'b100, 32'h0, 1'b0};
    txns[14] = '{32'h1, 32'h2, 3'b101, 32'h0, 1'b0};
    txns[15] = '{32'h1, 32'h2, 3'b001, 32'h3, 1'b1};

    runs[0] = '{0,  5, 32'd5, 32'd0, 32'd0, 32'd0, 32'd0, 32'h0};
    runs[1] = '{5,  3, 32'd2, 32'd1, 32'd0, 32'd1, 32'd6, 32'hCA};
    runs[2] = '{8,  2, 32'd0, 32'd1, 32'd1, 32'd0, 32'd6, 32'h0};
    runs[3] = '{10, 3, 32'd2, 32'd1, 32'd0, 32'd2, 32'd7, 32'h0};
    runs[4] = '{13, 3, 32'd0, 32'd1, 32'd2, 32'd2, 32'd1, 32'h3};

    rst_n    = 1'b0;
    start    = 1'b0;
    n_ops    = '0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    aluctrl  = '0;
    res      = '0;
    zero     = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("reset busy",     32'(busy),     32'd0);
    checkOutput("reset done",     32'(done),     32'd0);
    checkOutput("reset in_ready", 32'(in_ready), 32'd0);
    checkOutput("reset pass_cnt", 32'(pass_cnt), 32'd0);
    checkFirstFail("reset", 32'd0, 32'd0, 32'd0);
    rst_n = 1'b1;

    // Latency: count visible one cycle after acceptance, done with the last one
    $display("[TB] latency sequence");
    pulseStart(2);
    driveTxn(0);
    @(negedge clk);
    driveTxn(4);
    checkOutput("lat pass_cnt after 1", 32'(pass_cnt), 32'd1);
    checkOutput("lat busy after 1",     32'(busy),     32'd1);
    checkOutput("lat done after 1",     32'(done),     32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("lat done after 2",     32'(done),     32'd1);
    checkOutput("lat pass_cnt after 2", 32'(pass_cnt), 32'd2);

    $display("[TB] table runs");
    for (int r = 0; r < 5; r++) applyStimulus(r);

    // start asserted mid-run must not restart the run
    $display("[TB] start ignored in RUN");
    pulseStart(3);
    driveTxn(0);
    @(negedge clk);
    driveTxn(1);
    start = 1'b1;
    n_ops = CNT_W'(1);
    @(negedge clk);
    start = 1'b0;
    driveTxn(2);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("ignore done",     32'(done),     32'd1);
    checkOutput("ignore pass_cnt", 32'(pass_cnt), 32'd3);

    // n_ops = 0 from DONE: straight back to DONE with cleared counts
    $display("[TB] zero-length run from DONE");
    pulseStart(0);
    checkOutput("nops0 done",     32'(done),     32'd1);
    checkOutput("nops0 pass_cnt", 32'(pass_cnt), 32'd0);
    checkOutput("nops0 fail_cnt", 32'(fail_cnt), 32'd0);
    checkOutput("nops0 skip_cnt", 32'(skip_cnt), 32'd0);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("nops0 in_ready[%0d]", i), 32'(in_ready), 32'd0);
      @(negedge clk);
    end

    // Asynchronous reset after 2 of 4 transactions (one of them failing)
    $display("[TB] reset mid-run");
    pulseStart(4);
    driveTxn(0);
    @(negedge clk);
    driveTxn(6);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("midrst busy before",     32'(busy),     32'd1);
    checkOutput("midrst pass_cnt before", 32'(pass_cnt), 32'd1);
    checkOutput("midrst fail_cnt before", 32'(fail_cnt), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst busy",     32'(busy),     32'd0);
    checkOutput("midrst done",     32'(done),     32'd0);
    checkOutput("midrst in_ready", 32'(in_ready), 32'd0);
    checkOutput("midrst pass_cnt", 32'(pass_cnt), 32'd0);
    checkOutput("midrst fail_cnt", 32'(fail_cnt), 32'd0);
    checkFirstFail("midrst", 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // n_ops = 0 from IDLE, then a clean full run
    pulseStart(0);
    checkOutput("idle nops0 done",     32'(done),     32'd1);
    checkOutput("idle nops0 in_ready", 32'(in_ready), 32'd0);
    applyStimulus(0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
